strassen_product_scheduler: RTL and testbench

Sequencing controller for the 16x16 Strassen multiplier. It time-multiplexes one shared HxH systolic array (H = N/2) across the seven Strassen products M1..M7. It then drives four quadrant-combine steps that assemble C, and reports completion with a one-cycle done pulse. It sits between the top-level start/done handshake and the operand-mux/systolic-array/product-buffer datapath.

---
 rtl/strassen_pkg.sv | 33 +++
 rtl/strassen_timeout_ctr.sv | 28 ++
 rtl/strassen_product_scheduler.sv | 139 +++++++++++++
 tb/tb_strassen_product_scheduler.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/strassen_pkg.sv
// Shared encodings for the Strassen multiplier: operand-mux codes, quadrant ids
// and the per-product operand selection table used by scheduler and datapath.
package strassen_pkg;

    typedef enum logic [2:0] {
        Q11       = 3'd0,
        Q22       = 3'd1,
        Q11_P_Q22 = 3'd2,
        Q21_P_Q22 = 3'd3,
        Q11_P_Q12 = 3'd4,
        Q21_M_Q11 = 3'd5,
        Q12_M_Q22 = 3'd6,
        OP_RSVD   = 3'd7
    } op_sel_t;

    typedef enum logic [1:0] {
        C11 = 2'd0,
        C12 = 2'd1,
        C21 = 2'd2,
        C22 = 2'd3
    } quad_t;

    localparam int NUM_PRODUCTS = 7;

    // Index k selects M(k+1)
    localparam op_sel_t A_SEL_TBL [NUM_PRODUCTS] = '{
        Q11_P_Q22, Q21_P_Q22, Q11, Q22, Q11_P_Q12, Q21_M_Q11, Q12_M_Q22
    };
    localparam op_sel_t B_SEL_TBL [NUM_PRODUCTS] = '{
        Q11_P_Q22, Q11, Q12_M_Q22, Q21_M_Q11, Q22, Q11_P_Q12, Q21_P_Q22
    };

endpackage

// File: rtl/strassen_timeout_ctr.sv
// Watchdog counter for one product in flight; saturates at TIMEOUT-1 and
// reports expiry while parked there.
module strassen_timeout_ctr #(
    parameter int TIMEOUT = 256,
    parameter int TW      = $clog2(TIMEOUT)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

    logic [TW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en && !expired) begin
            cnt <= cnt + TW'(1);
        end
    end

    assign expired = (cnt == LAST);

endmodule

// File: rtl/strassen_product_scheduler.sv
// Sequences the seven Strassen products through one shared systolic array,
// then steps the four quadrant combines and pulses done.
module strassen_product_scheduler
    import strassen_pkg::*;
#(
    parameter int N       = 16,
    parameter int TIMEOUT = 256
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       sa_done,
    output logic       sa_start,
    output logic [2:0] a_sel,
    output logic [2:0] b_sel,
    output logic [2:0] m_idx,
    output logic       m_wr_en,
    output logic       comb_en,
    output logic [1:0] comb_quad,
    output logic       busy,
    output logic       done,
    output logic       error
);

    localparam int TW = $clog2(TIMEOUT);
    localparam logic [2:0] K_LAST = 3'(NUM_PRODUCTS - 1);

    if (N < 2 || (N % 2) != 0) begin : g_bad_n
        $error("N must be even and at least 2");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_COMBINE,
        S_FINISH
    } state_t;

    state_t     state, state_nx;
    logic [2:0] k, k_nx;
    logic [1:0] quad, quad_nx;
    logic       error_nx;
    logic       ctr_clr, ctr_en, expired;

    strassen_timeout_ctr #(
        .TIMEOUT (TIMEOUT),
        .TW      (TW)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clr     (ctr_clr),
        .en      (ctr_en),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            k     <= '0;
            quad  <= '0;
            error <= 1'b0;
        end else begin
            state <= state_nx;
            k     <= k_nx;
            quad  <= quad_nx;
            error <= error_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        k_nx      = k;
        quad_nx   = quad;
        error_nx  = error;
        ctr_clr   = 1'b0;
        ctr_en    = 1'b0;
        sa_start  = 1'b0;
        a_sel     = 3'd0;
        b_sel     = 3'd0;
        m_idx     = 3'd0;
        m_wr_en   = 1'b0;
        comb_en   = 1'b0;
        comb_quad = 2'd0;
        done      = 1'b0;
        busy      = (state != S_IDLE);

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = S_ISSUE;
                    k_nx     = '0;
                    error_nx = 1'b0;
                end
            end
            S_ISSUE: begin
                sa_start = 1'b1;
                a_sel    = A_SEL_TBL[k];
                b_sel    = B_SEL_TBL[k];
                m_idx    = k;
                ctr_clr  = 1'b1;
                state_nx = S_WAIT;
            end
            S_WAIT: begin
                m_idx  = k;
                ctr_en = 1'b1;
                // A product finishing on the last watchdog cycle is still accepted
                if (sa_done) begin
                    m_wr_en = 1'b1;
                    if (k == K_LAST) begin
                        state_nx = S_COMBINE;
                        quad_nx  = '0;
                    end else begin
                        k_nx     = k + 3'd1;
                        state_nx = S_ISSUE;
                    end
                end else if (expired) begin
                    error_nx = 1'b1;
                    state_nx = S_IDLE;
                end
            end
            S_COMBINE: begin
                comb_en   = 1'b1;
                comb_quad = quad;
                if (quad == 2'd3) begin
                    state_nx = S_FINISH;
                end else begin
                    quad_nx = quad + 2'd1;
                end
            end
            S_FINISH: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_strassen_product_scheduler.sv
// Directed bench for strassen_product_scheduler with a behavioural array model
// whose latency can be set per product, or withheld for one product.
module tb_strassen_product_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       sa_done;
    logic       sa_start;
    logic [2:0] a_sel, b_sel, m_idx;
    logic       m_wr_en, comb_en, busy, done, error;
    logic [1:0] comb_quad;

    always #5 clk = ~clk;

    strassen_product_scheduler #(
        .N       (16),
        .TIMEOUT (256)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .sa_done   (sa_done),
        .sa_start  (sa_start),
        .a_sel     (a_sel),
        .b_sel     (b_sel),
        .m_idx     (m_idx),
        .m_wr_en   (m_wr_en),
        .comb_en   (comb_en),
        .comb_quad (comb_quad),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    int cyc = 0;
    int base = 0;
    int errors = 0;
    int checks = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Array model: answers L cycles after sa_start, unless the product is dropped
    int   lat_tbl [7];
    int   drop_idx = -1;
    int   rem = 0;
    logic md = 1'b0;
    logic stray = 1'b0;
    assign sa_done = md | stray;

    always @(negedge clk) begin
        md = 1'b0;
        if (rst) begin
            rem = 0;
        end else begin
            if (rem > 0) begin
                rem = rem - 1;
                if (rem == 0) md = 1'b1;
            end
            if (sa_start && int'(m_idx) != drop_idx) rem = lat_tbl[m_idx];
        end
    end

    int ss_c[$], ss_a[$], ss_b[$], wr_c[$], wr_i[$], cb_c[$], cb_q[$], dn_c[$];

    always @(negedge clk) begin
        #2;
        if (sa_start) begin
            ss_c.push_back(cyc - base);
            ss_a.push_back(int'(a_sel));
            ss_b.push_back(int'(b_sel));
        end
        if (m_wr_en) begin
            wr_c.push_back(cyc - base);
            wr_i.push_back(int'(m_idx));
        end
        if (comb_en) begin
            cb_c.push_back(cyc - base);
            cb_q.push_back(int'(comb_quad));
        end
        if (done) dn_c.push_back(cyc - base);
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int exp_a [7] = '{2, 3, 0, 1, 4, 5, 6};
    int exp_b [7] = '{2, 0, 6, 5, 1, 4, 3};

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        ss_c.delete(); ss_a.delete(); ss_b.delete();
        wr_c.delete(); wr_i.delete();
        cb_c.delete(); cb_q.delete(); dn_c.delete();
    endtask

    task automatic set_lat(input int L);
        for (int i = 0; i < 7; i++) lat_tbl[i] = L;
    endtask

    task automatic launch();
        clear_logs();
        start = 1'b1;
        base  = cyc;
        step();
        start = 1'b0;
    endtask

    task automatic to_cycle(input int c);
        while (cyc - base < c) step();
    endtask

    task automatic wait_done(input string tag, input int limit);
        int n = 0;
        while (dn_c.size() == 0 && n < limit) begin
            step();
            n++;
        end
        chk({tag, "_done_seen"}, int'(dn_c.size() > 0), 1);
        step();
    endtask

    task automatic check_seq(input string tag, input int L);
        int p = L + 1;
        chk({tag, "_n_sa_start"}, ss_c.size(), 7);
        chk({tag, "_n_wr"}, wr_c.size(), 7);
        chk({tag, "_n_comb"}, cb_c.size(), 4);
        chk({tag, "_n_done"}, dn_c.size(), 1);
        for (int i = 0; i < 7; i++) begin
            if (i < ss_c.size()) begin
                chk($sformatf("%s_ss_cyc%0d", tag, i), ss_c[i], 1 + i * p);
                chk($sformatf("%s_a_sel%0d", tag, i), ss_a[i], exp_a[i]);
                chk($sformatf("%s_b_sel%0d", tag, i), ss_b[i], exp_b[i]);
            end
            if (i < wr_c.size()) begin
                chk($sformatf("%s_wr_cyc%0d", tag, i), wr_c[i], (i + 1) * p);
                chk($sformatf("%s_wr_idx%0d", tag, i), wr_i[i], i);
            end
        end
        for (int q = 0; q < 4; q++) begin
            if (q < cb_c.size()) begin
                chk($sformatf("%s_comb_cyc%0d", tag, q), cb_c[q], 7 * p + 1 + q);
                chk($sformatf("%s_comb_quad%0d", tag, q), cb_q[q], q);
            end
        end
        if (dn_c.size() > 0) chk({tag, "_done_cyc"}, dn_c[0], 7 * p + 5);
    endtask

    initial begin
        set_lat(22);
        step();
        step();
        step();
        chk("rst_outs", int'({sa_start, a_sel, b_sel, m_idx, m_wr_en, comb_en,
                              comb_quad, busy, done, error}), 0);
        rst = 1'b0;
        step();

        // Stray sa_done while idle
        stray = 1'b1;
        #1;
        chk("stray_idle_wr", int'(m_wr_en), 0);
        step();
        stray = 1'b0;
        chk("stray_idle_busy", int'(busy), 0);
        chk("stray_idle_sa_start", int'(sa_start), 0);

        // Full sequence, L = 22
        launch();
        chk("l22_sa_start_c1", int'(sa_start), 1);
        chk("l22_busy_c1", int'(busy), 1);
        to_cycle(30);
        chk("l22_m_idx_wait_m2", int'(m_idx), 1);
        chk("l22_sa_start_wait", int'(sa_start), 0);
        to_cycle(166);
        chk("l22_done_c166", int'(done), 1);
        chk("l22_busy_c166", int'(busy), 1);
        step();
        chk("l22_busy_c167", int'(busy), 0);
        chk("l22_done_c167", int'(done), 0);
        step();
        check_seq("l22", 22);

        // L = 1 with stray sa_done in ISSUE and COMBINE
        set_lat(1);
        launch();
        stray = 1'b1;
        #1;
        chk("stray_issue_wr", int'(m_wr_en), 0);
        step();
        stray = 1'b0;
        to_cycle(16);
        stray = 1'b1;
        #1;
        chk("stray_comb_wr", int'(m_wr_en), 0);
        chk("stray_comb_quad", int'(comb_quad), 1);
        step();
        stray = 1'b0;
        chk("stray_comb_next_quad", int'(comb_quad), 2);
        to_cycle(19);
        chk("l1_done_c19", int'(done), 1);
        step();
        step();
        check_seq("l1", 1);

        // sa_done on the last watchdog cycle is accepted
        set_lat(1);
        lat_tbl[0] = 256;
        launch();
        to_cycle(257);
        chk("coinc_wr", int'(m_wr_en), 1);
        chk("coinc_m_idx", int'(m_idx), 0);
        wait_done("coinc", 100);
        chk("coinc_n_wr", wr_c.size(), 7);
        if (dn_c.size() > 0) chk("coinc_done_cyc", dn_c[0], 274);
        chk("coinc_error", int'(error), 0);

        // Array never answers M4
        set_lat(1);
        drop_idx = 3;
        launch();
        to_cycle(7);
        chk("to_sa_start_m4", int'(sa_start), 1);
        chk("to_m_idx_m4", int'(m_idx), 3);
        to_cycle(263);
        chk("to_busy_c263", int'(busy), 1);
        chk("to_error_c263", int'(error), 0);
        step();
        chk("to_error_c264", int'(error), 1);
        chk("to_busy_c264", int'(busy), 0);
        step();
        step();
        chk("to_no_done", dn_c.size(), 0);
        chk("to_n_wr", wr_c.size(), 3);
        chk("to_error_sticky", int'(error), 1);
        drop_idx = -1;
        launch();
        chk("to_restart_error_clr", int'(error), 0);
        chk("to_restart_busy", int'(busy), 1);
        wait_done("to_restart", 40);
        if (dn_c.size() > 0) chk("to_restart_done_cyc", dn_c[0], 19);

        // Reset during WAIT of M3
        set_lat(22);
        launch();
        to_cycle(50);
        chk("rmid_m_idx", int'(m_idx), 2);
        chk("rmid_busy", int'(busy), 1);
        rst = 1'b1;
        step();
        chk("rmid_outs", int'({sa_start, a_sel, b_sel, m_idx, m_wr_en, comb_en,
                               comb_quad, busy, done, error}), 0);
        rst = 1'b0;
        step();
        set_lat(1);
        launch();
        wait_done("rmid_restart", 40);
        step();
        check_seq("rmid", 1);

        // start held high for 200 cycles
        set_lat(22);
        clear_logs();
        start = 1'b1;
        base  = cyc;
        to_cycle(200);
        start = 1'b0;
        if (dn_c.size() > 0) chk("hold_done1_cyc", dn_c[0], 166);
        if (ss_c.size() > 7) chk("hold_ss_m1_again", ss_c[7], 168);
        if (ss_c.size() > 6) chk("hold_ss_m7", ss_c[6], 139);
        to_cycle(336);
        chk("hold_n_sa_start", ss_c.size(), 14);
        chk("hold_n_done", dn_c.size(), 2);
        if (dn_c.size() > 1) chk("hold_done2_cyc", dn_c[1], 333);
        chk("hold_busy_end", int'(busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
